// File: rtl/cdb_arbiter.sv
// Complete-stage CDB arbiter: per-unit one-entry holding buffers drained round-robin onto a registered CDB.
// Optional mispredict flush port enabled by defining CDB_ARB_FLUSH_EN.
module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned XLEN   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
`ifdef CDB_ARB_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*XLEN-1:0]   fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_data,
    output logic [NUM_FU-1:0]        grant
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] hold_valid_q, hold_valid_d;
    logic [TAG_W-1:0]  hold_tag_q  [NUM_FU];
    logic [TAG_W-1:0]  hold_tag_d  [NUM_FU];
    logic [XLEN-1:0]   hold_data_q [NUM_FU];
    logic [XLEN-1:0]   hold_data_d [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]   cdb_data_q, cdb_data_d;

    logic              flush_c;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  scan_ptr;

`ifdef CDB_ARB_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Round-robin scan of the holding buffers starting at rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_ptr  = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            scan_ptr = PTR_W'((32'(rr_ptr_q) + i) % NUM_FU);
            if (!win_found && hold_valid_q[scan_ptr]) begin
                win_found = 1'b1;
                win_idx   = scan_ptr;
            end
        end
        if (flush_c) begin
            win_found = 1'b0;
        end
    end

    always_comb begin
        grant = '0;
        if (win_found) begin
            grant[win_idx] = 1'b1;
        end
        fu_ready = flush_c ? '0 : (~hold_valid_q | grant);
    end

    // Next state: drain the winner, refill accepted buffers, register the broadcast.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        hold_data_d  = hold_data_q;
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = 1'b0;
        cdb_tag_d    = cdb_tag_q;
        cdb_data_d   = cdb_data_q;

        if (win_found) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = hold_tag_q[win_idx];
            cdb_data_d  = hold_data_q[win_idx];
            rr_ptr_d    = (32'(win_idx) == NUM_FU - 1) ? '0 : win_idx + PTR_W'(1);
        end

        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                hold_valid_d[i] = 1'b0;
            end
            // Tag 0 is the hardwired zero register: handshake it but never broadcast.
            if (fu_valid[i] && fu_ready[i] && (fu_tag[i*TAG_W +: TAG_W] != '0)) begin
                hold_valid_d[i] = 1'b1;
                hold_tag_d[i]   = fu_tag[i*TAG_W +: TAG_W];
                hold_data_d[i]  = fu_data[i*XLEN +: XLEN];
            end
        end

        if (flush_c) begin
            hold_valid_d = '0;
            cdb_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                hold_tag_q[i]  <= '0;
                hold_data_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                hold_tag_q[i]  <= hold_tag_d[i];
                hold_data_q[i] <= hold_data_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (4 units, 6-bit tags, 32-bit data).
module tb_cdb_arbiter;

    localparam int unsigned NUM_FU = 4;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned XLEN   = 32;

    logic                    clock;
    logic                    reset;
    logic                    flush;
    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]  fu_data;
    logic [NUM_FU-1:0]       fu_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_data;
    logic [NUM_FU-1:0]       grant;

    int n_checks;
    int n_pass;

    cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef CDB_ARB_FLUSH_EN
        .flush     (flush),
`endif
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .grant     (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
        fu_valid[i]              = v;
        fu_tag[i*TAG_W +: TAG_W] = t;
        fu_data[i*XLEN +: XLEN]  = d;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;

        // Reset state
        tick();
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_fu_ready", 64'(fu_ready), 64'hF);
        check("rst_grant", 64'(grant), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_cdb_valid", 64'(cdb_valid), 64'd0);

        // Full contention from rr_ptr=0: tags 10..13 in order
        for (int i = 0; i < 4; i++) set_fu(i, 1'b1, TAG_W'(10 + i), XLEN'(100 + i));
        tick();
        fu_valid = '0;
        check("cont_grant0", 64'(grant), 64'b0001);
        check("cont_ready0", 64'(fu_ready), 64'b0001);
        check("cont_valid0", 64'(cdb_valid), 64'd0);
        tick();
        check("cont_tag10", 64'(cdb_tag), 64'd10);
        check("cont_data10", 64'(cdb_data), 64'd100);
        check("cont_valid1", 64'(cdb_valid), 64'd1);
        check("cont_grant1", 64'(grant), 64'b0010);
        check("cont_ready3_a", 64'(fu_ready[3]), 64'd0);
        tick();
        check("cont_tag11", 64'(cdb_tag), 64'd11);
        check("cont_grant2", 64'(grant), 64'b0100);
        check("cont_ready3_b", 64'(fu_ready[3]), 64'd0);
        tick();
        check("cont_tag12", 64'(cdb_tag), 64'd12);
        check("cont_grant3", 64'(grant), 64'b1000);
        check("cont_ready3_c", 64'(fu_ready[3]), 64'd1);
        tick();
        check("cont_tag13", 64'(cdb_tag), 64'd13);
        check("cont_data13", 64'(cdb_data), 64'd103);
        check("cont_grant_idle", 64'(grant), 64'd0);
        tick();
        check("cont_valid_end", 64'(cdb_valid), 64'd0);

        // Single request on unit 1
        set_fu(1, 1'b1, 6'd7, 32'hDEAD);
        #1;
        check("single_ready", 64'(fu_ready), 64'hF);
        tick();
        fu_valid = '0;
        check("single_grant", 64'(grant), 64'b0010);
        check("single_valid_k", 64'(cdb_valid), 64'd0);
        tick();
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_tag", 64'(cdb_tag), 64'd7);
        check("single_data", 64'(cdb_data), 64'hDEAD);
        tick();
        check("single_one_cycle", 64'(cdb_valid), 64'd0);
        check("single_tag_hold", 64'(cdb_tag), 64'd7);

        // Fairness: rr_ptr=2, units 0 and 2 both keep feeding; broadcasts alternate 20,30,21,31
        set_fu(0, 1'b1, 6'd30, 32'h300);
        set_fu(2, 1'b1, 6'd20, 32'h200);
        tick();
        check("fair_grant_a", 64'(grant), 64'b0100);
        check("fair_ready_a", 64'(fu_ready), 64'b1110);
        set_fu(2, 1'b1, 6'd21, 32'h210);
        set_fu(0, 1'b1, 6'd31, 32'h310);
        tick();
        check("fair_tag20", 64'(cdb_tag), 64'd20);
        check("fair_grant_b", 64'(grant), 64'b0001);
        fu_valid[2] = 1'b0;
        tick();
        check("fair_tag30", 64'(cdb_tag), 64'd30);
        check("fair_data30", 64'(cdb_data), 64'h300);
        check("fair_grant_c", 64'(grant), 64'b0100);
        fu_valid = '0;
        tick();
        check("fair_tag21", 64'(cdb_tag), 64'd21);
        check("fair_grant_d", 64'(grant), 64'b0001);
        tick();
        check("fair_tag31", 64'(cdb_tag), 64'd31);
        check("fair_data31", 64'(cdb_data), 64'h310);
        check("fair_valid_e", 64'(cdb_valid), 64'd1);
        check("fair_grant_e", 64'(grant), 64'd0);

        // Zero tag is handshaked but dropped
        set_fu(1, 1'b1, 6'd0, 32'h55);
        #1;
        check("zero_ready", 64'(fu_ready[1]), 64'd1);
        tick();
        fu_valid = '0;
        check("zero_grant", 64'(grant), 64'd0);
        check("zero_valid", 64'(cdb_valid), 64'd0);
        tick();
        check("zero_valid2", 64'(cdb_valid), 64'd0);

        // Async reset mid-cycle with buffers 0 and 2 full and a broadcast in flight (rr_ptr=1)
        set_fu(0, 1'b1, 6'd40, 32'h400);
        set_fu(2, 1'b1, 6'd42, 32'h420);
        tick();
        fu_valid = '0;
        set_fu(2, 1'b1, 6'd44, 32'h440);
        check("arst_grant", 64'(grant), 64'b0100);
        tick();
        fu_valid = '0;
        check("arst_pre_valid", 64'(cdb_valid), 64'd1);
        check("arst_pre_tag", 64'(cdb_tag), 64'd42);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(cdb_valid), 64'd0);
        check("arst_ready", 64'(fu_ready), 64'hF);
        check("arst_grant0", 64'(grant), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        check("arst_no_stale1", 64'(cdb_valid), 64'd0);
        check("arst_grant_idle", 64'(grant), 64'd0);
        tick();
        check("arst_no_stale2", 64'(cdb_valid), 64'd0);

`ifdef CDB_ARB_FLUSH_EN
        // Flush with buffers 1 and 3 full: nothing is broadcast, new request accepted after
        set_fu(1, 1'b1, 6'd51, 32'h510);
        set_fu(3, 1'b1, 6'd53, 32'h530);
        tick();
        fu_valid = '0;
        flush = 1'b1;
        set_fu(0, 1'b1, 6'd55, 32'h550);
        #1;
        check("flush_ready", 64'(fu_ready), 64'd0);
        check("flush_grant", 64'(grant), 64'd0);
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        #1;
        check("flush_valid_after", 64'(cdb_valid), 64'd0);
        check("flush_grant_after", 64'(grant), 64'd0);
        check("flush_ready_after", 64'(fu_ready), 64'hF);
        set_fu(3, 1'b1, 6'd60, 32'h600);
        tick();
        fu_valid = '0;
        check("flush_new_grant", 64'(grant), 64'b1000);
        check("flush_new_valid0", 64'(cdb_valid), 64'd0);
        tick();
        check("flush_new_tag", 64'(cdb_tag), 64'd60);
        check("flush_new_valid", 64'(cdb_valid), 64'd1);
        tick();
        check("flush_idle", 64'(cdb_valid), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Complete-stage arbiter sharing the single common data bus (CDB) among the execute-stage functional units (ALU, multiplier, load, branch). Each unit hands its finished result (destination physical tag plus data) to a one-entry holding buffer. A round-robin scheduler drains one buffer per cycle onto a registered CDB broadcast. That broadcast drives map-table/RS tag wakeup, ROB completion and the PRF write.

## Interface
- NUM_FU, 4, number of requesting functional units (2..8)
- TAG_W, 6, physical register tag width
- XLEN, 32, result data width
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- fu_valid  in  NUM_FU  per-unit result valid
- fu_tag  in  NUM_FU*TAG_W  per-unit destination tag, unit i at [i*TAG_W +: TAG_W]
- fu_data  in  NUM_FU*XLEN  per-unit result, unit i at [i*XLEN +: XLEN]
- fu_ready  out  NUM_FU  unit i may present a result this cycle (combinational)
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast tag (registered)
- cdb_data  out  XLEN  broadcast data / PRF write data (registered)
- grant  out  NUM_FU  one-hot, buffer drained this cycle (combinational)
- flush  in  1  mispredict squash; present only with CDB_ARB_FLUSH_EN

## Operation
- State: per-unit hold_valid/hold_tag/hold_data; rr_ptr (clog2(NUM_FU) bits); cdb_valid/cdb_tag/cdb_data registers.
- Acceptance: fu_ready[i] = ~hold_valid[i] | grant[i]. On an edge with fu_valid[i] & fu_ready[i], the buffer loads tag/data and hold_valid[i] is set.
- Tag 0 (architectural zero reg): a request with fu_tag = 0 is handshaked but never loaded, so it is never broadcast.
- Arbitration: scan hold_valid starting at rr_ptr, wrapping modulo NUM_FU. The first set entry wins and grant has exactly that bit. If no buffer is valid, grant = 0.
- On an edge with a winner w: cdb_valid<=1, cdb_tag<=hold_tag[w], cdb_data<=hold_data[w], and rr_ptr<=(w+1) mod NUM_FU. hold_valid[w] clears unless it reloads the same edge.
- On an edge with no winner: cdb_valid<=0 and rr_ptr holds. cdb_tag/cdb_data hold their last value.
- Simultaneous drain and refill of the same buffer is legal, and the new entry is eligible next cycle.
- The CDB has no backpressure. Every grant yields exactly one broadcast.

## Timing
- Reset values: hold_valid=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0. Hence fu_ready=all ones and grant=0 during and after reset.
- Latency, uncontended: a result accepted at edge k is granted in cycle k→k+1. It is broadcast (cdb_valid=1) from edge k+1 for exactly one cycle.
- Throughput: one broadcast per cycle while any buffer is valid. A unit can stream back-to-back only if it is granted each cycle.
- Contention: a unit that loses keeps fu_ready=0 and holds its buffer. Round-robin bounds its wait to NUM_FU-1 cycles.
- Reset asserted mid-operation drops all buffered and in-flight broadcasts asynchronously.

## Configuration
- CDB_ARB_FLUSH_EN defined: the flush port exists. On an edge with flush=1, all hold_valid and cdb_valid clear, rr_ptr is unchanged, and no grant is made. fu_ready=0 and grant=0 while flush=1, and fu_valid is ignored. The broadcast registered before the flush edge remains visible during the flush cycle.
- CDB_ARB_FLUSH_EN undefined: no flush port and no flush logic. Buffers drain only via grant.

## Test plan
- Reset: assert reset asynchronously mid-cycle with buffers 0 and 2 full → cdb_valid=0 and fu_ready=4'b1111 immediately. After release, no stale broadcast appears.
- Single request: fu_valid=4'b0010, tag=7, data=32'hDEAD at edge k → cdb_valid=1, cdb_tag=7, cdb_data=32'hDEAD after edge k+1 for one cycle. rr_ptr becomes 2.
- Full contention: all four units valid at edge k, tags 10..13, rr_ptr=0 → broadcasts tag 10, 11, 12, 13 on consecutive cycles. fu_ready[3]=0 for 3 cycles.
- Fairness: unit 0 streams continuously while unit 2 holds one result (tag 20) → unit 2 is broadcast within 2 cycles, and the two alternate rather than unit 0 monopolising.
- Zero tag: fu_valid[1]=1 with fu_tag=0 → fu_ready[1]=1, no grant, cdb_valid stays 0.
- Flush (CDB_ARB_FLUSH_EN): buffers 1 and 3 full, flush=1 for one edge → no later broadcast of either tag. fu_ready=0 during the flush cycle, and a new request is accepted the cycle after.
